// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampling UART receiver that buffers each good frame
// in a first-word-fall-through FIFO. Framing errors and overruns are reported
// as single-cycle pulses.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Tick,
    input  logic        RxEn,
    input  logic        Rx,
    input  logic [3:0]  NBits,
    input  logic        RdEn,
    output logic [7:0]  RdData,
    output logic        Empty,
    output logic        Full,
    output logic [AW:0] Count,
    output logic        FrameErr,
    output logic        Overrun
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rxState_t;

    localparam logic [AW:0] DepthWords = (AW+1)'(DEPTH);

    logic          rxMeta;
    logic          rs;
    logic          prevRs;
    rxState_t      state, stateNext;
    logic [3:0]    sampleCnt, sampleCntNext;
    logic [2:0]    bitIdx, bitIdxNext;
    logic [3:0]    nBitsLat, nBitsLatNext;
    logic [7:0]    shiftReg, shiftRegNext;
    logic [2:0]    samples, samplesNext;
    logic [3:0]    nBitsClamped;
    logic          majority;
    logic          pushReq;
    logic          frameErrNext;
    logic          push;
    logic          pop;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   cnt;

    // Frame widths outside 5..8 are pinned to the nearest legal width.
    assign nBitsClamped = (NBits < 4'd5) ? 4'd5 : ((NBits > 4'd8) ? 4'd8 : NBits);

    // 2-of-3 vote over the mid-bit samples taken at counts 7, 8 and 9.
    assign majority = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                      (samples[1] & samples[2]);

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rxMeta <= 1'b1;
            rs     <= 1'b1;
        end else begin
            // NOTE: non-blocking, so rs takes the pre-edge rxMeta and the two flops form a real chain.
            rxMeta <= Rx;
            rs     <= rxMeta;
        end
    end

    // Line level seen on the previous Tick, for start-edge detection.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            prevRs <= 1'b1;
        end else if (Tick) begin
            prevRs <= rs;
        end
    end

    // Receiver next-state logic: bit timing, sampling and frame evaluation.
    always_comb begin
        // NOTE: every signal is defaulted first, so no path through the branches infers a latch.
        stateNext     = state;
        sampleCntNext = sampleCnt;
        bitIdxNext    = bitIdx;
        nBitsLatNext  = nBitsLat;
        shiftRegNext  = shiftReg;
        samplesNext   = samples;
        pushReq       = 1'b0;
        frameErrNext  = 1'b0;
        if (!RxEn) begin
            stateNext     = IDLE;
            sampleCntNext = 4'd0;
            bitIdxNext    = 3'd0;
            samplesNext   = 3'd0;
        end else if (Tick) begin
            if (state == IDLE) begin
                if (!rs && prevRs) begin
                    stateNext     = START;
                    sampleCntNext = 4'd0;
                    bitIdxNext    = 3'd0;
                    nBitsLatNext  = nBitsClamped;
                    shiftRegNext  = 8'd0;
                    samplesNext   = 3'd0;
                end
            end else begin
                sampleCntNext = sampleCnt + 4'd1;
                if (sampleCnt >= 4'd7 && sampleCnt <= 4'd9) begin
                    samplesNext = {samples[1:0], rs};
                end
                if (sampleCnt == 4'd15) begin
                    case (state)
                        START: begin
                            stateNext  = majority ? IDLE : DATA;
                            bitIdxNext = 3'd0;
                        end
                        DATA: begin
                            shiftRegNext[bitIdx] = majority;
                            if ({1'b0, bitIdx} == nBitsLat - 4'd1) begin
                                stateNext = STOP;
                            end else begin
                                bitIdxNext = bitIdx + 3'd1;
                            end
                        end
                        STOP: begin
                            pushReq      = majority;
                            frameErrNext = !majority;
                            stateNext    = IDLE;
                        end
                        default: stateNext = IDLE;
                    endcase
                end
            end
        end
    end

    // Receiver state registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            sampleCnt <= 4'd0;
            bitIdx    <= 3'd0;
            nBitsLat  <= 4'd8;
            shiftReg  <= 8'd0;
            samples   <= 3'd0;
        end else begin
            state     <= stateNext;
            sampleCnt <= sampleCntNext;
            bitIdx    <= bitIdxNext;
            nBitsLat  <= nBitsLatNext;
            shiftReg  <= shiftRegNext;
            samples   <= samplesNext;
        end
    end

    // A full FIFO still accepts the word when a pop happens in the same cycle.
    assign pop  = RdEn && !Empty;
    assign push = pushReq && (!Full || pop);

    // Registered single-cycle error pulses.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            FrameErr <= 1'b0;
            Overrun  <= 1'b0;
        end else begin
            FrameErr <= frameErrNext;
            Overrun  <= pushReq && !push;
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            // NOTE: storage is cleared on reset so the fall-through head reads 0 rather than stale data.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'd0;
            end
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
        end else begin
            if (push) begin
                mem[wrPtr] <= shiftRegNext;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign RdData = mem[rdPtr];
    assign Empty  = (cnt == '0);
    assign Full   = (cnt == DepthWords);
    assign Count  = cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized
// frames compared against a queue-based model of the receiver and FIFO.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          Clk   = 1'b0;
    logic          Rst_n = 1'b0;
    logic          Tick  = 1'b0;
    logic          RxEn  = 1'b0;
    logic          Rx    = 1'b1;
    logic [3:0]    NBits = 4'd8;
    logic          RdEn  = 1'b0;
    logic [7:0]    RdData;
    logic          Empty;
    logic          Full;
    logic [AW:0]   Count;
    logic          FrameErr;
    logic          Overrun;

    int total = 0;
    int bad   = 0;
    int expFerr = 0;
    int expOvr  = 0;
    int seenFerr = 0;
    int seenOvr  = 0;
    int tickPhase;
    logic [7:0] modelQ[$];

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Tick(Tick), .RxEn(RxEn), .Rx(Rx),
        .NBits(NBits), .RdEn(RdEn), .RdData(RdData), .Empty(Empty),
        .Full(Full), .Count(Count), .FrameErr(FrameErr), .Overrun(Overrun)
    );

    always #5 Clk = ~Clk;

    // Tick strobe: one Clk cycle in every four.
    initial begin
        tickPhase = 0;
        forever begin
            @(posedge Clk);
            #1;
            Tick = (tickPhase == 3);
            tickPhase = (tickPhase + 1) % 4;
        end
    end

    // Count high cycles of each error pulse; one pulse must be one cycle.
    always @(negedge Clk) begin
        if (FrameErr === 1'b1) seenFerr++;
        if (Overrun === 1'b1) seenOvr++;
    end

    initial begin
        #800us;
        $display("FAIL watchdog: simulation still running at %0t, limit 800us", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic waitTick();
        do @(posedge Clk); while (Tick !== 1'b1);
        #2;
    endtask

    // Reference behaviour of one frame, from the frame rules alone.
    task automatic modelFrame(input logic [7:0] data, input int wireBits,
                              input logic stopVal, input logic popAtStop);
        int effN;
        logic [7:0] word;
        logic stopSeen;
        effN = (NBits < 4'd5) ? 5 : ((NBits > 4'd8) ? 8 : int'(NBits));
        word = data & 8'((1 << effN) - 1);
        stopSeen = (effN < wireBits) ? data[effN] : stopVal;
        if (popAtStop && modelQ.size() > 0) void'(modelQ.pop_front());
        if (stopSeen) begin
            if (modelQ.size() < DEPTH) modelQ.push_back(word);
            else expOvr++;
        end else begin
            expFerr++;
        end
    endtask

    // Drive one frame on Rx at 16 Ticks per bit, LSB first.
    task automatic sendFrame(input logic [7:0] data, input int wireBits,
                             input logic stopVal, input int gap, input logic popAtStop);
        Rx = 1'b0;
        repeat (16) waitTick();
        for (int i = 0; i < wireBits; i++) begin
            Rx = data[i];
            repeat (16) waitTick();
        end
        Rx = stopVal;
        repeat (16) waitTick();
        Rx = 1'b1;
        if (popAtStop) begin
            do begin @(posedge Clk); #2; end while (Tick !== 1'b1);
            RdEn = 1'b1;
            @(posedge Clk);
            #2;
            RdEn = 1'b0;
            repeat (gap - 1) waitTick();
        end else begin
            repeat (gap) waitTick();
        end
        modelFrame(data, wireBits, stopVal, popAtStop);
    endtask

    task automatic popWord();
        RdEn = 1'b1;
        @(posedge Clk);
        #2;
        RdEn = 1'b0;
        if (modelQ.size() > 0) void'(modelQ.pop_front());
    endtask

    task automatic test_reset();
        RxEn = 1'b0;
        Rst_n = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        total++;
        if ({Empty, Full, Count, RdData, FrameErr, Overrun} !== {1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values: got E=%b F=%b C=%0d D=%h FE=%b OV=%b want E=1 F=0 C=0 D=00 FE=0 OV=0",
                     Empty, Full, Count, RdData, FrameErr, Overrun);
        end
        Rst_n = 1'b1;
        RxEn = 1'b1;
        repeat (8) waitTick();
        total++;
        if (Empty !== 1'b1 || Count !== 4'd0) begin
            bad++;
            $display("FAIL idle_after_reset: got E=%b C=%0d want E=1 C=0", Empty, Count);
        end
    endtask

    task automatic test_basic();
        NBits = 4'd8;
        sendFrame(8'hA5, 8, 1'b1, 2, 1'b0);
        total++;
        if (Empty !== 1'b0 || Count !== 4'd1 || RdData !== 8'hA5) begin
            bad++;
            $display("FAIL basic_a5: got E=%b C=%0d D=%h want E=0 C=1 D=a5", Empty, Count, RdData);
        end
        total++;
        if (seenFerr != 0 || seenOvr != 0) begin
            bad++;
            $display("FAIL basic_pulses: got ferr=%0d ovr=%0d want 0 0", seenFerr, seenOvr);
        end
        popWord();
        total++;
        if (Empty !== 1'b1) begin
            bad++;
            $display("FAIL basic_pop: got E=%b want 1", Empty);
        end
    endtask

    task automatic test_nbits();
        NBits = 4'd5;
        sendFrame(8'hFF, 8, 1'b1, 2, 1'b0);
        total++;
        if (Count !== 4'd1 || RdData !== 8'h1F) begin
            bad++;
            $display("FAIL nbits5_zero_ext: got C=%0d D=%h want C=1 D=1f", Count, RdData);
        end
        popWord();
        NBits = 4'd3;
        sendFrame(8'h15, 5, 1'b1, 2, 1'b0);
        total++;
        if (Count !== 4'd1 || RdData !== 8'h15) begin
            bad++;
            $display("FAIL nbits3_clamped: got C=%0d D=%h want C=1 D=15", Count, RdData);
        end
        popWord();
        NBits = 4'd8;
    endtask

    task automatic test_overrun();
        int ovrBase;
        ovrBase = seenOvr;
        for (int i = 1; i <= 9; i++) begin
            sendFrame(8'(i), 8, 1'b1, 2, 1'b0);
            if (i == 8) begin
                total++;
                if (Full !== 1'b1 || Count !== 4'd8 || seenOvr != ovrBase) begin
                    bad++;
                    $display("FAIL full_after_8: got F=%b C=%0d ovr=%0d want F=1 C=8 ovr=0",
                             Full, Count, seenOvr - ovrBase);
                end
            end
        end
        total++;
        if (seenOvr - ovrBase != 1 || Count !== 4'd8) begin
            bad++;
            $display("FAIL overrun_9th: got ovr=%0d C=%0d want ovr=1 C=8", seenOvr - ovrBase, Count);
        end
        for (int i = 1; i <= 8; i++) begin
            total++;
            if (Empty !== 1'b0 || RdData !== 8'(i)) begin
                bad++;
                $display("FAIL drain_order: got E=%b D=%h want E=0 D=%h", Empty, RdData, 8'(i));
            end
            popWord();
        end
        total++;
        if (Empty !== 1'b1 || Count !== 4'd0) begin
            bad++;
            $display("FAIL drain_empty: got E=%b C=%0d want E=1 C=0", Empty, Count);
        end
    endtask

    task automatic test_full_pop();
        int ovrBase;
        for (int i = 1; i <= 8; i++) sendFrame(8'(i), 8, 1'b1, 2, 1'b0);
        ovrBase = seenOvr;
        sendFrame(8'h99, 8, 1'b1, 2, 1'b1);
        total++;
        if (Count !== 4'd8 || Full !== 1'b1 || RdData !== 8'h02 || seenOvr != ovrBase) begin
            bad++;
            $display("FAIL full_pop_push: got C=%0d F=%b D=%h ovr=%0d want C=8 F=1 D=02 ovr=0",
                     Count, Full, RdData, seenOvr - ovrBase);
        end
        while (modelQ.size() > 0) begin
            total++;
            if (RdData !== modelQ[0]) begin
                bad++;
                $display("FAIL full_pop_drain: got D=%h want D=%h", RdData, modelQ[0]);
            end
            popWord();
        end
    endtask

    task automatic test_frame_err();
        int ferrBase;
        ferrBase = seenFerr;
        sendFrame(8'h3C, 8, 1'b0, 2, 1'b0);
        total++;
        if (seenFerr - ferrBase != 1 || Count !== 4'd0) begin
            bad++;
            $display("FAIL frame_err: got ferr_cycles=%0d C=%0d want 1 C=0", seenFerr - ferrBase, Count);
        end
        ferrBase = seenFerr;
        Rx = 1'b0;
        repeat (4) waitTick();
        Rx = 1'b1;
        repeat (40) waitTick();
        total++;
        if (Count !== 4'd0 || seenFerr != ferrBase || seenOvr != expOvr) begin
            bad++;
            $display("FAIL glitch_ignored: got C=%0d ferr=%0d ovr=%0d want C=0 ferr=0 ovr=%0d",
                     Count, seenFerr - ferrBase, seenOvr, expOvr);
        end
    endtask

    task automatic test_rxen_abort();
        logic [7:0] partial;
        partial = 8'hAA;
        sendFrame(8'h11, 8, 1'b1, 2, 1'b0);
        Rx = 1'b0;
        repeat (16) waitTick();
        for (int i = 0; i < 3; i++) begin
            Rx = partial[i];
            repeat (16) waitTick();
        end
        RxEn = 1'b0;
        Rx = 1'b1;
        repeat (4) waitTick();
        total++;
        if (Empty !== 1'b0 || RdData !== 8'h11) begin
            bad++;
            $display("FAIL read_while_disabled: got E=%b D=%h want E=0 D=11", Empty, RdData);
        end
        popWord();
        repeat (20) waitTick();
        RxEn = 1'b1;
        repeat (4) waitTick();
        sendFrame(8'h55, 8, 1'b1, 2, 1'b0);
        total++;
        if (Count !== 4'd1 || RdData !== 8'h55 || seenFerr != expFerr || seenOvr != expOvr) begin
            bad++;
            $display("FAIL rxen_abort: got C=%0d D=%h ferr=%0d ovr=%0d want C=1 D=55 ferr=%0d ovr=%0d",
                     Count, RdData, seenFerr, seenOvr, expFerr, expOvr);
        end
        popWord();
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 3; i++) sendFrame(8'($urandom), 8, 1'b1, 2, 1'b0);
        total++;
        if (Count !== 4'd3) begin
            bad++;
            $display("FAIL prefill_3: got C=%0d want 3", Count);
        end
        Rx = 1'b0;
        repeat (16) waitTick();
        Rx = 1'b1;
        repeat (20) waitTick();
        #3;
        Rst_n = 1'b0;
        #1;
        total++;
        if (Empty !== 1'b1 || Count !== 4'd0 || Full !== 1'b0 || RdData !== 8'd0) begin
            bad++;
            $display("FAIL async_reset: got E=%b C=%0d F=%b D=%h want E=1 C=0 F=0 D=00",
                     Empty, Count, Full, RdData);
        end
        modelQ.delete();
        repeat (3) @(posedge Clk);
        #2;
        Rst_n = 1'b1;
        repeat (40) waitTick();
        total++;
        if (Empty !== 1'b1 || seenFerr != expFerr) begin
            bad++;
            $display("FAIL post_reset_idle: got E=%b ferr=%0d want E=1 ferr=%0d", Empty, seenFerr, expFerr);
        end
    endtask

    task automatic test_random();
        int effN;
        int nPops;
        for (int f = 0; f < 12; f++) begin
            NBits = 4'($urandom_range(0, 15));
            effN = (NBits < 4'd5) ? 5 : ((NBits > 4'd8) ? 8 : int'(NBits));
            sendFrame(8'($urandom), effN, ($urandom_range(0, 7) != 0),
                      int'($urandom_range(1, 4)), ($urandom_range(0, 3) == 0));
            total++;
            if (Count !== (AW+1)'(modelQ.size()) || Empty !== (modelQ.size() == 0) ||
                Full !== (modelQ.size() == DEPTH) ||
                (modelQ.size() > 0 && RdData !== modelQ[0])) begin
                bad++;
                $display("FAIL random_frame_%0d: got C=%0d E=%b F=%b D=%h want C=%0d head=%h",
                         f, Count, Empty, Full, RdData, modelQ.size(),
                         (modelQ.size() > 0) ? modelQ[0] : 8'h00);
            end
            total++;
            if (seenFerr != expFerr || seenOvr != expOvr) begin
                bad++;
                $display("FAIL random_pulses_%0d: got ferr=%0d ovr=%0d want ferr=%0d ovr=%0d",
                         f, seenFerr, seenOvr, expFerr, expOvr);
            end
            nPops = int'($urandom_range(0, 1));
            repeat (nPops) popWord();
        end
        while (modelQ.size() > 0) begin
            total++;
            if (RdData !== modelQ[0]) begin
                bad++;
                $display("FAIL random_drain: got D=%h want D=%h", RdData, modelQ[0]);
            end
            popWord();
        end
        popWord();
        total++;
        if (Empty !== 1'b1 || Count !== 4'd0) begin
            bad++;
            $display("FAIL pop_when_empty: got E=%b C=%0d want E=1 C=0", Empty, Count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nbits();
        test_overrun();
        test_full_pop();
        test_frame_err();
        test_rxen_abort();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
